// File: rtl/traffic_pkg.sv
// Shared types and default timing for the intersection scheduler.
package traffic_pkg;

  localparam int unsigned MIN_GREEN_DEF = 4;
  localparam int unsigned MAX_GREEN_DEF = 12;
  localparam int unsigned YELLOW_T_DEF  = 2;
  localparam int unsigned ALLRED_T_DEF  = 1;
  localparam int unsigned WALK_T_DEF    = 6;
  localparam int unsigned TW_DEF        = 4;
  localparam int unsigned FLASH_HALF    = 8;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    WALK      = 3'd5,
    FLASH     = 3'd6
  } state_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic walk;
  } lamps_t;

  localparam lamps_t LAMPS_ALL_RED = 7'b100_100_0;

  // Lamp pattern shown while in state s; flash_on only matters in FLASH.
  function automatic lamps_t lamps_for(input state_e s, input logic flash_on);
    lamps_t l;
    l = '0;
    case (s)
      NS_GREEN:  begin l.ns_green  = 1'b1; l.ew_red    = 1'b1; end
      NS_YELLOW: begin l.ns_yellow = 1'b1; l.ew_red    = 1'b1; end
      EW_GREEN:  begin l.ns_red    = 1'b1; l.ew_green  = 1'b1; end
      EW_YELLOW: begin l.ns_red    = 1'b1; l.ew_yellow = 1'b1; end
      WALK:      begin l.ns_red    = 1'b1; l.ew_red    = 1'b1; l.walk = 1'b1; end
      FLASH:     begin l.ns_yellow = flash_on; l.ew_red = flash_on; end
      default:   begin l.ns_red    = 1'b1; l.ew_red    = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating TW-bit phase counter with synchronous clear and a terminal-value compare.
module phase_timer #(
  parameter int unsigned TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [TW-1:0] term,
  output logic [TW-1:0] count,
  output logic          done_c
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != {TW{1'b1}}) begin
      count <= count + TW'(1);
    end
  end

  assign done_c = (count == term);

endmodule

// File: rtl/intersection_scheduler.sv
// Demand-driven NS/EW signal sequencer with pedestrian walk phase.
// Optional night flashing mode is enabled by defining NIGHT_FLASH_EN.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = MIN_GREEN_DEF,
  parameter int unsigned MAX_GREEN = MAX_GREEN_DEF,
  parameter int unsigned YELLOW_T  = YELLOW_T_DEF,
  parameter int unsigned ALLRED_T  = ALLRED_T_DEF,
  parameter int unsigned WALK_T    = WALK_T_DEF,
  parameter int unsigned TW        = TW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ns_car,
  input  logic ew_car,
  input  logic ped_btn,
`ifdef NIGHT_FLASH_EN
  input  logic night,
`endif
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic walk,
  output logic ped_wait
);

  localparam logic [TW-1:0] T_MING   = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_MAXG   = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] T_WALK   = TW'(WALK_T - 1);

  state_e        state, next_state;
  dir_e          next_dir, next_dir_n;
  logic          ped_pend, ped_pend_n;
  logic          from_walk, from_walk_n;
  logic [TW-1:0] tcount, tterm;
  logic          tdone;
  logic          green_open;
  logic          night_req;
  logic          flash_on_n;
  lamps_t        lamps, lamps_n;

  phase_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (next_state != state),
    .term   (tterm),
    .count  (tcount),
    .done_c (tdone)
  );

  // Terminal count for the fixed-length phases; greens use green_open instead.
  always_comb begin
    tterm = T_MING;
    case (state)
      ALL_RED:              tterm = T_ALLRED;
      NS_YELLOW, EW_YELLOW: tterm = T_YELLOW;
      WALK:                 tterm = T_WALK;
      default:              tterm = T_MING;
    endcase
  end

  // Past MIN_GREEN any request ends green, so the MAX_GREEN bound is always covered.
  assign green_open = (tcount >= T_MING) || (tcount >= T_MAXG);

`ifdef NIGHT_FLASH_EN
  logic          flash_on;
  logic [TW-1:0] fcount;
  logic          fdone;
  logic          unused_fcount;

  phase_timer #(.TW(TW)) u_flash (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state != FLASH) || fdone),
    .term   (TW'(FLASH_HALF - 1)),
    .count  (fcount),
    .done_c (fdone)
  );

  assign unused_fcount = ^fcount;
  assign night_req     = night;

  always_comb begin
    flash_on_n = 1'b0;
    if (next_state == FLASH) begin
      if (state != FLASH) flash_on_n = 1'b1;
      else if (fdone)     flash_on_n = ~flash_on;
      else                flash_on_n = flash_on;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flash_on <= 1'b0;
    else      flash_on <= flash_on_n;
  end
`else
  assign night_req  = 1'b0;
  assign flash_on_n = 1'b0;
`endif

  // Next-state, direction and pedestrian bookkeeping.
  always_comb begin
    next_state = state;
    next_dir_n = next_dir;
    case (state)
      ALL_RED: begin
        if (tdone) begin
          if (ped_pend && !from_walk)  next_state = WALK;
          else if (next_dir == DIR_NS) next_state = NS_GREEN;
          else                         next_state = EW_GREEN;
          if (night_req)               next_state = FLASH;
        end
      end
      NS_GREEN: begin
        if (green_open && (ew_car || ped_pend || night_req)) begin
          next_state = NS_YELLOW;
          next_dir_n = DIR_EW;
        end
      end
      EW_GREEN: begin
        if (green_open && (ns_car || ped_pend || night_req)) begin
          next_state = EW_YELLOW;
          next_dir_n = DIR_NS;
        end
      end
      NS_YELLOW, EW_YELLOW, WALK: begin
        if (tdone) next_state = ALL_RED;
      end
      FLASH: begin
        if (!night_req) begin
          next_state = ALL_RED;
          next_dir_n = DIR_NS;
        end
      end
      default: next_state = ALL_RED;
    endcase
  end

  // A press on the walk-entry edge survives the clear and waits for the next walk.
  assign ped_pend_n  = ped_btn || (ped_pend && !((next_state == WALK) && (state != WALK)));
  assign from_walk_n = (next_state == ALL_RED) &&
                       ((state == WALK) || ((state == ALL_RED) && from_walk));
  assign lamps_n     = lamps_for(next_state, flash_on_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ALL_RED;
      next_dir  <= DIR_NS;
      ped_pend  <= 1'b0;
      from_walk <= 1'b0;
      lamps     <= LAMPS_ALL_RED;
    end else begin
      state     <= next_state;
      next_dir  <= next_dir_n;
      ped_pend  <= ped_pend_n;
      from_walk <= from_walk_n;
      lamps     <= lamps_n;
    end
  end

  assign ns_red    = lamps.ns_red;
  assign ns_yellow = lamps.ns_yellow;
  assign ns_green  = lamps.ns_green;
  assign ew_red    = lamps.ew_red;
  assign ew_yellow = lamps.ew_yellow;
  assign ew_green  = lamps.ew_green;
  assign walk      = lamps.walk;
  assign ped_wait  = ped_pend;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed and random checks for intersection_scheduler with a lamp scoreboard.
`timescale 1ns/1ps
module tb_intersection_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ns_car = 1'b0, ew_car = 1'b0, ped_btn = 1'b0;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_wait;
`ifdef NIGHT_FLASH_EN
  logic night = 1'b0;
`endif

  always #5 clk = ~clk;

  intersection_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .ns_car    (ns_car),
    .ew_car    (ew_car),
    .ped_btn   (ped_btn),
`ifdef NIGHT_FLASH_EN
    .night     (night),
`endif
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green),
    .walk      (walk),
    .ped_wait  (ped_wait)
  );

  // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_wait}
  logic [7:0] obs;
  assign obs = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_wait};

  localparam logic [7:0] AR  = 8'b1001_0000;
  localparam logic [7:0] NSG = 8'b0011_0000;
  localparam logic [7:0] NSY = 8'b0101_0000;
  localparam logic [7:0] EWG = 8'b1000_0100;
  localparam logic [7:0] EWY = 8'b1000_1000;
  localparam logic [7:0] WK  = 8'b1001_0010;
  localparam logic [7:0] P   = 8'b0000_0001;
  localparam logic [7:0] FON = 8'b0101_0000;
  localparam logic [7:0] FOF = 8'b0000_0000;
  localparam int PED_LIMIT = 2 * (12 + 2 + 1) + 6;

  typedef struct {
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  int  ns_run, ew_run, age;
  bit  pend, btn, prev_walk, prev_ns, prev_ew;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (obs === e.v) begin
      passes++;
    end else begin
      $error("FAIL %s: got %b expected %b", e.tag, obs, e.v);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Push one expectation per cycle, advance the clock, then retire it.
  task automatic expect_n(input int n, input logic [7:0] v, input string tag);
    for (int k = 0; k < n; k++) begin
      push(v, tag);
      tick();
      check_out();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    push(AR, "reset_state");
    check_out();

    // Idle release: one all-red cycle, then NS rests in green.
    rst = 1'b1;
    expect_n(51, NSG, "ns_rest");

    // Fresh NS green, EW demand from green cycle 1.
    rst = 1'b0;
    #1;
    push(AR, "reset_mid_green");
    check_out();
    tick();
    rst = 1'b1;
    expect_n(1, NSG, "t2_green0");
    ew_car = 1'b1;
    expect_n(3, NSG, "t2_green");
    expect_n(2, NSY, "t2_yellow");
    expect_n(1, AR,  "t2_allred");
    expect_n(1, EWG, "t2_ew_green");
    ew_car = 1'b0;

    // Pedestrian press at EW green timer 6.
    expect_n(6, EWG, "t3_ew_rest");
    ped_btn = 1'b1;
    expect_n(1, EWG | P, "t3_ped_latch");
    ped_btn = 1'b0;
    expect_n(2, EWY | P, "t3_yellow");
    expect_n(1, AR | P,  "t3_allred");
    expect_n(6, WK,      "t3_walk");
    expect_n(1, AR,      "t3_allred_post");
    expect_n(1, NSG,     "t3_ns_green");

    // Reach EW yellow with a pending press, then reset asynchronously.
    ew_car = 1'b1;
    expect_n(3, NSG, "t4_ns_green");
    expect_n(2, NSY, "t4_ns_yellow");
    expect_n(1, AR,  "t4_allred");
    expect_n(1, EWG, "t4_ew_green0");
    ew_car  = 1'b0;
    ns_car  = 1'b1;
    ped_btn = 1'b1;
    expect_n(1, EWG | P, "t4_ped_latch");
    ped_btn = 1'b0;
    expect_n(2, EWG | P, "t4_ew_green");
    expect_n(1, EWY | P, "t4_ew_yellow");
    #2;
    rst = 1'b0;
    #1;
    push(AR, "t4_async_reset");
    check_out();
    ns_car = 1'b0;
    tick();
    push(AR, "t4_reset_hold");
    check_out();
    rst = 1'b1;
    expect_n(1, NSG, "t4_restart");

    // Random sensors and button: safety, minimum green, pedestrian latency.
    ns_run = ns_green ? 1 : 0;
    ew_run = ew_green ? 1 : 0;
    pend   = 1'b0;
    age    = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 15) == 0) ns_car = ~ns_car;
      if ($urandom_range(0, 15) == 0) ew_car = ~ew_car;
      ped_btn   = ($urandom_range(0, 39) == 0);
      btn       = ped_btn;
      prev_walk = walk;
      prev_ns   = ns_green;
      prev_ew   = ew_green;
      tick();
      check_val("safety", 32'((ns_green | ns_yellow) & (ew_green | ew_yellow)), 32'd0);
      if (ns_green) ns_run++;
      else if (prev_ns) begin
        check_val("min_green_ns", 32'(ns_run >= 4), 32'd1);
        ns_run = 0;
      end
      if (ew_green) ew_run++;
      else if (prev_ew) begin
        check_val("min_green_ew", 32'(ew_run >= 4), 32'd1);
        ew_run = 0;
      end
      if (walk && !prev_walk) pend = 1'b0;
      if (btn && !pend) begin
        pend = 1'b1;
        age  = 0;
      end else if (pend) begin
        age++;
      end
      if (pend) check_val("ped_latency", 32'(age <= PED_LIMIT), 32'd1);
    end
    ns_car  = 1'b0;
    ew_car  = 1'b0;
    ped_btn = 1'b0;

`ifdef NIGHT_FLASH_EN
    // Night request at NS green timer 5, flash, then return to day operation.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    expect_n(6, NSG, "fl_ns_green");
    night = 1'b1;
    expect_n(2, NSY, "fl_yellow");
    expect_n(1, AR,  "fl_allred");
    expect_n(8, FON, "fl_on1");
    expect_n(8, FOF, "fl_off");
    expect_n(3, FON, "fl_on2");
    night = 1'b0;
    expect_n(1, AR,  "fl_exit_allred");
    expect_n(2, NSG, "fl_ns_green_after");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
